serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_ctrl.sv | 117 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder with valid/ready handshakes on both sides.
// One full adder processes one operand bit per cycle, LSB first.

module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;
  logic             carry_q;
  logic             cout_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] mask;
  logic             fa_s;
  logic             fa_c;

  // Shift instead of bit-select so the index width never matters.
  assign a_sh = a_q >> cnt_q;
  assign b_sh = b_q >> cnt_q;
  assign mask = WIDTH'(1) << cnt_q;

  full_adder u_fa (
    .a_i(a_sh[0]),
    .b_i(b_sh[0]),
    .c_i(carry_q),
    .s_o(fa_s),
    .c_o(fa_c)
  );

  assign sum_d = fa_s ? (sum_q | mask) : (sum_q & ~mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= c_in;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= fa_c;
          if (cnt_q == LAST) begin
            cout_q  <= fa_c;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign c_out     = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8 and WIDTH=1).
// Expected sums are hand-computed constants.

module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       c_in = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] sum;
  logic       c_out;
  logic       busy;

  logic in_valid1 = 1'b0;
  logic a1 = 1'b0;
  logic b1 = 1'b0;
  logic c_in1 = 1'b0;
  logic out_ready1 = 1'b0;
  logic in_ready1;
  logic out_valid1;
  logic sum1;
  logic c_out1;
  logic busy1;

  int passed = 0;
  int fails = 0;
  int total = 0;
  int n;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .busy(busy)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .c_in(c_in1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .c_out(c_out1), .busy(busy1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept, measure latency, check result, then hand it off.
  task automatic run_op(input string tag,
                        input logic [7:0] va,
                        input logic [7:0] vb,
                        input logic vc,
                        input logic [7:0] es,
                        input logic ec);
    in_valid = 1'b1;
    a = va;
    b = vb;
    c_in = vc;
    step();
    in_valid = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'd8);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout"}, 32'(c_out), 32'(ec));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #12;
    chk("rst_rdy", 32'(in_ready), 32'd1);
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(c_out), 32'd0);
    rst_n = 1'b1;
    step();

    run_op("op0f01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
    run_op("opff00", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
    run_op("opa55a", 8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0);
    run_op("op8080", 8'h80, 8'h80, 1'b1, 8'h01, 1'b1);

    // out_ready held high during RUN must not cut the operation short
    out_ready = 1'b1;
    in_valid = 1'b1;
    a = 8'h12;
    b = 8'h34;
    c_in = 1'b0;
    step();
    in_valid = 1'b0;
    repeat (7) step();
    chk("ign_rdy_run", 32'(out_valid), 32'd0);
    step();
    chk("ign_rdy_vld", 32'(out_valid), 32'd1);
    chk("ign_rdy_sum", 32'(sum), 32'h46);
    step();
    out_ready = 1'b0;
    chk("ign_rdy_idle", 32'(in_ready), 32'd1);

    // backpressure
    in_valid = 1'b1;
    a = 8'h33;
    b = 8'h44;
    c_in = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (8) step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_vld", 32'(out_valid), 32'd1);
      chk("bp_rdy", 32'(in_ready), 32'd0);
      chk("bp_sum", 32'(sum), 32'h78);
      chk("bp_cout", 32'(c_out), 32'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_idle", 32'(in_ready), 32'd1);
    chk("bp_vld0", 32'(out_valid), 32'd0);

    // in_valid pulse during RUN with different operands
    in_valid = 1'b1;
    a = 8'h3C;
    b = 8'h11;
    c_in = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    in_valid = 1'b1;
    a = 8'hFF;
    b = 8'hFF;
    c_in = 1'b1;
    step();
    in_valid = 1'b0;
    chk("ign_in_rdy", 32'(in_ready), 32'd0);
    repeat (4) step();
    chk("ign_in_vld", 32'(out_valid), 32'd1);
    chk("ign_in_sum", 32'(sum), 32'h4E);
    chk("ign_in_cout", 32'(c_out), 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // reset abort at bit 4
    in_valid = 1'b1;
    a = 8'hFF;
    b = 8'h01;
    c_in = 1'b0;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    chk("abort_busy0", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_vld", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(c_out), 32'd0);
    #2;
    rst_n = 1'b1;
    chk("abort_rdy", 32'(in_ready), 32'd1);
    run_op("op0101", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

    // WIDTH=1 instance
    in_valid1 = 1'b1;
    a1 = 1'b1;
    b1 = 1'b1;
    c_in1 = 1'b1;
    step();
    in_valid1 = 1'b0;
    chk("w1_busy", 32'(busy1), 32'd1);
    chk("w1_vld0", 32'(out_valid1), 32'd0);
    step();
    chk("w1_vld", 32'(out_valid1), 32'd1);
    chk("w1_sum", 32'(sum1), 32'd1);
    chk("w1_cout", 32'(c_out1), 32'd1);
    out_ready1 = 1'b1;
    step();
    out_ready1 = 1'b0;
    chk("w1_idle", 32'(in_ready1), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
